// File: rtl/dmem_handshake_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_handshake_bridge_pkg
// Description : Shared types and constants for the data-memory handshake
//               bridge. This package holds the FSM state encoding, the default
//               REQ-phase timeout, and an address alignment helper.
//               The optional timeout logic is enabled by defining the
//               DMEM_TIMEOUT_EN macro.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_handshake_bridge_pkg;

    // Bridge FSM encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Default number of REQ cycles without ack before the access is aborted
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Returns 1 when a byte address is word aligned
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage : dmem_handshake_bridge_pkg
`default_nettype wire

// File: rtl/dmem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_timeout_counter
// Description : Counts REQ cycles in which no ack arrived. 'expired' is raised
//               combinationally in the cycle in which the count would reach
//               LIMIT. This means a REQ phase that never sees an ack ends after
//               exactly LIMIT cycles. The bridge instantiates this module only
//               when DMEM_TIMEOUT_EN is defined.
// Ports       : clk     - clock, rising edge
//               rst     - synchronous reset, active low
//               clear   - zero the count (asserted outside REQ)
//               enable  - count this cycle (REQ without ack)
//               expired - limit reached this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_timeout_counter #(
    parameter int LIMIT = 255                // must be >= 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // At least 8 bits, wider if LIMIT needs it
    localparam int CW = (LIMIT < 256) ? 8 : $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The count holds the number of ack-less REQ cycles before this one, so
    // this cycle is the LIMIT-th when count equals LIMIT-1.
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule : dmem_timeout_counter
`default_nettype wire

// File: rtl/dmem_handshake_bridge.sv
`default_nettype none
// ============================================================================
// Module      : dmem_handshake_bridge
// Description : Bridges the CPU's MEM phase to a variable-latency data SRAM
//               over a req/ack handshake. The bridge captures one load or
//               store, then holds the memory request until it is acknowledged.
//               It registers load data and stalls the CPU until a one-cycle
//               cpu_done pulse.
//               Optional feature: define DMEM_TIMEOUT_EN to abort a REQ phase
//               after TIMEOUT_CYCLES cycles without ack (completes with err).
// Ports       : clk, rst (sync, active low)
//               cpu_read/cpu_write/cpu_addr/cpu_wdata - CPU request (level)
//               cpu_rdata/cpu_stall/cpu_done/cpu_err  - CPU response
//               mem_req/mem_we/mem_addr/mem_wdata     - memory request
//               mem_ack/mem_rdata                     - memory response
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_handshake_bridge
    import dmem_handshake_bridge_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              cpu_done,
    output logic              cpu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t state;
    state_t state_nxt;

    logic   req_any;
    logic   aligned;
    logic   timeout_hit;
    logic   err_q;

    assign req_any = cpu_read | cpu_write;
    assign aligned = is_word_aligned(cpu_addr[1:0]);

    // ------------------------------------------------------------------
    // Optional REQ-phase timeout
    // ------------------------------------------------------------------
`ifdef DMEM_TIMEOUT_EN
    logic tmo_clear;
    logic tmo_enable;

    // Clearing in every non-REQ cycle means the count is zero on REQ entry
    assign tmo_clear  = (state != REQ);
    assign tmo_enable = (state == REQ) && !mem_ack;

    dmem_timeout_counter #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and CPU-side outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        cpu_done  = 1'b0;
        cpu_stall = 1'b0;
        cpu_err   = 1'b0;

        unique case (state)
            IDLE: begin
                // Stall goes combinationally from the request, so the CPU
                // holds in the same cycle in which it asks.
                cpu_stall = req_any;
                if (req_any) begin
                    state_nxt = aligned ? REQ : DONE;
                end
            end
            REQ: begin
                cpu_stall = 1'b1;
                // Ack wins over a timeout in the same cycle
                if (mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                cpu_done  = 1'b1;
                cpu_err   = err_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request capture, memory-side outputs and load data
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            err_q     <= 1'b0;
        end else begin
            // Registered request: high exactly while the FSM sits in REQ
            mem_req <= (state_nxt == REQ);

            if ((state == IDLE) && req_any) begin
                // Simultaneous read+write is resolved as a write but flagged
                err_q <= (cpu_read & cpu_write) | !aligned;
                // Memory-side fields move only for accesses that reach memory
                if (aligned) begin
                    mem_we    <= cpu_write;
                    mem_addr  <= {cpu_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata <= cpu_wdata;
                end
            end

            if (state == REQ) begin
                if (mem_ack) begin
                    if (!mem_we) begin
                        cpu_rdata <= mem_rdata;
                    end
                end else if (timeout_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

endmodule : dmem_handshake_bridge
`default_nettype wire

// File: tb/tb_dmem_handshake_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_handshake_bridge
// Description : Scoreboard testbench for dmem_handshake_bridge. The stimulus
//               pushes the expected outcome of each transaction. A monitor
//               checks memory-side fields on every mem_req cycle and pops or
//               compares on every cpu_done. DMEM_TIMEOUT_EN selects the
//               timeout or wait-forever scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_handshake_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall, cpu_done, cpu_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          has_mem;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    dmem_handshake_bridge #(
        .ADDR_W         (32),
        .DATA_W         (32),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .cpu_done  (cpu_done),
        .cpu_err   (cpu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (rst) begin
            if (mem_req) begin
                if (exp_q.size() == 0 || !exp_q[0].has_mem) begin
                    check("mem_req_unexpected", 128'(mem_req), 128'd0);
                end else begin
                    check("mem_fields", {mem_we, mem_addr, mem_wdata},
                          {exp_q[0].we, exp_q[0].addr, exp_q[0].wdata});
                end
            end
            if (cpu_done) begin
                if (exp_q.size() == 0) begin
                    check("done_unexpected", 128'(cpu_done), 128'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("done_resp", {cpu_err, cpu_rdata, mem_req},
                          {mon_e.err, mon_e.rdata, 1'b0});
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // One complete transaction with a memory that acks after 'delay'
    // stalled REQ cycles
    // ------------------------------------------------------------------
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, input int delay,
                           input logic [31:0] rv, input bit has_mem,
                           input bit err, input logic [31:0] exp_rd,
                           input int exp_lat, input int exp_reqc);
        exp_t x;
        int   lat  = 0;
        int   reqc = 0;
        bit   seen = 0;
        x.has_mem = has_mem;
        x.we      = wr;
        x.addr    = {a[31:2], 2'b00};
        x.wdata   = wd;
        x.err     = err;
        x.rdata   = exp_rd;
        exp_q.push_back(x);
        @(posedge clk); #1;
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = a;
        cpu_wdata = wd;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            mem_ack = 1'b0;
            if (cpu_done) begin
                seen      = 1;
                cpu_read  = 1'b0;
                cpu_write = 1'b0;
                check("stall_in_done", 128'(cpu_stall), 128'd0);
            end else begin
                if (cpu_stall !== 1'b1) check("stall_busy", 128'(cpu_stall), 128'd1);
                if (mem_req) begin
                    if (reqc == delay) begin
                        mem_ack   = 1'b1;
                        mem_rdata = rv;
                    end
                    reqc++;
                end
            end
        end
        check("txn_latency", 128'(lat), 128'(exp_lat));
        check("req_cycles", 128'(reqc), 128'(exp_reqc));
    endtask

    // Request that is never acked, then abandoned with reset
    task automatic hang_then_reset(input logic [31:0] a, input int ncyc);
        exp_t x;
        x.has_mem = 1;
        x.we      = 0;
        x.addr    = a;
        x.wdata   = cpu_wdata;
        x.err     = 0;
        x.rdata   = 32'h0;
        exp_q.push_back(x);
        @(posedge clk); #1;
        cpu_read = 1'b1;
        cpu_addr = a;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (cpu_stall !== 1'b1) check("hang_stall", 128'(cpu_stall), 128'd1);
        end
        check("hang_in_req", 128'(mem_req), 128'd1);
        rst      = 1'b0;
        cpu_read = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
        check("midreq_reset_outs",
              {cpu_rdata, cpu_stall, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_wdata},
              128'd0);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (cpu_done !== 1'b0) check("no_done_after_reset", 128'(cpu_done), 128'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs",
              {cpu_rdata, cpu_stall, cpu_done, cpu_err, mem_req, mem_we, mem_addr, mem_wdata},
              128'd0);
        rst = 1'b1;

        // Zero-wait read
        run_txn(1, 0, 32'h10, 32'h0, 0, 32'h1234_5678, 1, 0, 32'h1234_5678, 3, 1);
        // Write, ack after 4 stalled cycles (5 REQ cycles)
        run_txn(0, 1, 32'h20, 32'hCAFE_F00D, 4, 32'hDEAD_DEAD, 1, 0, 32'h1234_5678, 7, 5);
        // Misaligned read: no memory access, rdata unchanged
        run_txn(1, 0, 32'h22, 32'hCAFE_F00D, 0, 32'h0, 0, 1, 32'h1234_5678, 2, 0);
        // Read and write together: write issued, error flagged
        run_txn(1, 1, 32'h30, 32'hA5A5_5A5A, 1, 32'hDEAD_BEEF, 1, 1, 32'h1234_5678, 4, 2);
        // Read with 2 wait cycles
        run_txn(1, 0, 32'h44, 32'h0, 2, 32'h0BAD_F00D, 1, 0, 32'h0BAD_F00D, 5, 3);

        // Ack while idle is ignored
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check("idle_ack_ignored", {cpu_rdata, mem_req, cpu_stall, cpu_done},
              {32'h0BAD_F00D, 3'b000});
        mem_ack = 1'b0;

`ifdef DMEM_TIMEOUT_EN
        // No ack ever: aborted after 8 REQ cycles, rdata unchanged
        run_txn(1, 0, 32'h48, 32'h0, 1000, 32'h0, 1, 1, 32'h0BAD_F00D, 10, 8);
`else
        // No ack ever: bridge keeps stalling until reset
        hang_then_reset(32'h48, 20);
`endif
        // Reset in the middle of REQ abandons the transaction
        hang_then_reset(32'h50, 3);
        // Bridge recovers after reset
        run_txn(1, 0, 32'h58, 32'h0, 0, 32'h0000_0077, 1, 0, 32'h0000_0077, 3, 1);

        repeat (2) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_dmem_handshake_bridge
`default_nettype wire

// File: doc/dmem_handshake_bridge.md
# dmem_handshake_bridge

Bridge between the multi-cycle CPU's MEM phase and a variable-latency data SRAM using a req/ack handshake. Captures one load or store request from the control/datapath side, drives and holds a memory transaction until acknowledged, registers the load data, and stalls the CPU FSM until a one-cycle completion pulse. Replaces the fixed single-cycle data memory path so slower memories can be attached without changing the CPU datapath.

## Interface
Parameters:
- ADDR_W, 32, address width (matches `ADDR_LEN`)
- DATA_W, 32, data width (matches `DATA_LEN`)
- TIMEOUT_CYCLES, 255, max REQ cycles before abort; used only with the timeout feature

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-low reset
- cpu_read  in  1  load request (level; held until cpu_done)
- cpu_write  in  1  store request (level; held until cpu_done)
- cpu_addr  in  ADDR_W  byte address (EX/MEM ALU output)
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  registered load data
- cpu_stall  out  1  CPU must not advance its state
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  error qualifier, valid only with cpu_done
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  ADDR_W  word-aligned address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory completion, sampled only in REQ
- mem_rdata  in  DATA_W  read data, valid with mem_ack

## Operation
- States: IDLE, REQ, DONE.
- IDLE: when cpu_read | cpu_write is sampled, latch addr/wdata/we. Write wins if both are high; that transaction finishes with cpu_err = 1.
- IDLE with misaligned address (cpu_addr[1:0] != 0): no memory access. Go to DONE with err = 1; cpu_rdata unchanged.
- IDLE with aligned address: go to REQ; mem_req = 1 from the next cycle.
- REQ: mem_req, mem_we, mem_addr and mem_wdata are held stable. On mem_ack, a read captures mem_rdata into cpu_rdata, then go to DONE.
- DONE: cpu_done = 1 and cpu_stall = 0 for exactly one cycle, mem_req = 0, then return to IDLE unconditionally.
- The CPU drops its request in the cycle cpu_done is seen. A request still high in the following IDLE cycle starts a new transaction.
- cpu_stall = (IDLE & (cpu_read | cpu_write)) | REQ. The IDLE term is combinational from the request.
- mem_ack in IDLE or DONE is ignored.
- Reset values: state IDLE, cpu_rdata 0, all 1-bit outputs 0, mem_addr 0, mem_wdata 0.

## Timing
- Zero-wait memory (ack asserted in the first REQ cycle): request at cycle 0, REQ at cycle 1, DONE at cycle 2. This 3-cycle latency is the minimum.
- Each extra cycle with mem_ack low adds one cycle.
- cpu_rdata is valid from the DONE cycle and holds until the next successful read.
- A misaligned access completes in 2 cycles: request, then DONE.
- Reset asserted mid-REQ: at that edge mem_req goes to 0 and the state goes to IDLE. The transaction is abandoned with no cpu_done.

## Configuration
- `DMEM_TIMEOUT_EN` defined: an 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, go to DONE with cpu_err = 1 and mem_req = 0 next cycle; cpu_rdata is unchanged.
  - An ack in the same cycle as the limit takes priority, and the transaction succeeds.
- Not defined: no counter exists, and REQ waits indefinitely for mem_ack.

## Structure
- Shared defines: state encoding (IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2), the default TIMEOUT_CYCLES and the `DMEM_TIMEOUT_EN` guard belong in `defines.v` beside the `ADDR_LEN`/`DATA_LEN` constants.
- One sub-module, `dmem_timeout_counter`, instantiated only under the macro. Ports: clk, rst, clear, enable, expired.

## Test plan
- Read, ack on first REQ cycle, mem_rdata = 32'h1234_5678, cpu_addr = 32'h10 -> mem_req high cycle 1 only, cpu_done cycle 2, cpu_rdata = 32'h1234_5678, cpu_err = 0.
- Write, addr 32'h20, wdata 32'hCAFE_F00D, ack delayed 4 cycles -> mem_we = 1, addr/wdata stable across all 5 REQ cycles, cpu_stall high throughout, single cpu_done.
- Misaligned read at 32'h22 -> no mem_req ever, cpu_done + cpu_err next cycle, cpu_rdata keeps its previous value.
- cpu_read and cpu_write both high -> a write transaction is issued; cpu_done with cpu_err = 1.
- Reset low during REQ -> mem_req = 0 after the edge, no cpu_done, all outputs at reset values.
- With `DMEM_TIMEOUT_EN` and TIMEOUT_CYCLES = 8, mem_ack tied low -> cpu_done + cpu_err after 8 REQ cycles, cpu_rdata unchanged. The same stimulus without the macro stalls forever.
